// File: rtl/servo_cmd_ramp_if.sv
// Position command handshake between a command source and the servo slew stage.
interface servo_cmd_ramp_if;
    logic        cmd_valid;
    logic [15:0] cmd_pos;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_pos,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_pos,
        output cmd_ready
    );
endinterface

// File: rtl/servo_cmd_ramp.sv
// Clamps absolute servo position commands and slews the PWM control word toward them,
// at most STEP counts per PWM frame tick.
module servo_cmd_ramp #(
    parameter int unsigned MAX_POS  = 25000,
    parameter int unsigned STEP     = 1000,
    parameter int unsigned INIT_POS = 12500
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_frame_tick,
    servo_cmd_ramp_if.slave        cmd_if,
    output logic [15:0]            o_control,
    output logic                   o_moving,
    output logic                   o_cmd_err
);

    localparam logic [15:0] LP_MAX    = 16'(MAX_POS);
    localparam logic [15:0] LP_INIT   = 16'(INIT_POS);
    localparam logic [15:0] LP_STEP16 = 16'(STEP);
    localparam logic [16:0] LP_STEP17 = 17'(STEP);

    typedef enum logic {StIdle, StRamp} state_t;

    state_t      r_state;
    logic [15:0] r_control;
    logic [15:0] r_target;
    logic        r_moving;
    logic        r_cmd_err;
    logic        r_cmd_ready;

    logic        w_accept;
    logic        w_over;
    logic [15:0] w_clamped;
    logic        w_up;
    logic [16:0] w_dist;
    logic [15:0] w_step_ctrl;
    logic [15:0] w_ctrl_next;
    logic [15:0] w_tgt_next;
    logic        w_ramp_next;

    always_comb begin
        w_accept  = cmd_if.cmd_valid & r_cmd_ready;
        w_over    = cmd_if.cmd_pos > LP_MAX;
        w_clamped = w_over ? LP_MAX : cmd_if.cmd_pos;

        // Distance in 17 bits so the unsigned compare against STEP can never wrap.
        w_up   = r_target >= r_control;
        w_dist = w_up ? ({1'b0, r_target} - {1'b0, r_control})
                      : ({1'b0, r_control} - {1'b0, r_target});

        if (w_dist <= LP_STEP17) begin
            w_step_ctrl = r_target;
        end else if (w_up) begin
            w_step_ctrl = r_control + LP_STEP16;
        end else begin
            w_step_ctrl = r_control - LP_STEP16;
        end

        // The step always uses the target held before this edge.
        w_ctrl_next = ((r_state == StRamp) && i_frame_tick) ? w_step_ctrl : r_control;
        w_tgt_next  = w_accept ? w_clamped : r_target;
        w_ramp_next = w_tgt_next != w_ctrl_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_control   <= LP_INIT;
            r_target    <= LP_INIT;
            r_moving    <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_cmd_ready <= 1'b1;
            r_control   <= w_ctrl_next;
            r_target    <= w_tgt_next;
            r_cmd_err   <= w_accept & w_over;
            r_state     <= w_ramp_next ? StRamp : StIdle;
            r_moving    <= w_ramp_next;
        end
    end

    assign cmd_if.cmd_ready = r_cmd_ready;
    assign o_control        = r_control;
    assign o_moving         = r_moving;
    assign o_cmd_err        = r_cmd_err;

endmodule

// File: tb/tb_servo_cmd_ramp.sv
// Directed bench for servo_cmd_ramp: reset, ramps, clamping, retargeting and reset mid-ramp.
module tb_servo_cmd_ramp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [15:0] control;
    logic        moving;
    logic        cmd_err;

    int n_checks = 0;
    int n_errors = 0;

    servo_cmd_ramp_if bus ();

    servo_cmd_ramp dut (
        .clk          (clk),
        .rst          (rst),
        .i_frame_tick (frame_tick),
        .cmd_if       (bus.slave),
        .o_control    (control),
        .o_moving     (moving),
        .o_cmd_err    (cmd_err)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock one edge, then sample 1 time unit later.
    task automatic cyc(input logic r, input logic v, input logic [15:0] p, input logic ft);
        rst           = r;
        bus.cmd_valid = v;
        bus.cmd_pos   = p;
        frame_tick    = ft;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        frame_tick    = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [31:0] c, input logic [31:0] m);
        chk({tag, "_control"}, 32'(control), c);
        chk({tag, "_moving"}, 32'(moving), m);
    endtask

    task automatic fresh_reset();
        cyc(1'b1, 1'b0, 16'd0, 1'b0);
        cyc(1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_pos   = 16'd0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 16'd0, 1'b1);
            chk_state("rst", 12500, 0);
            chk("rst_err", 32'(cmd_err), 0);
            chk("rst_ready", 32'(bus.cmd_ready), 0);
        end
        cyc(1'b0, 1'b0, 16'd0, 1'b0);
        chk("rel_ready", 32'(bus.cmd_ready), 1);
        chk_state("rel", 12500, 0);

        // Basic ramp to 15500
        cyc(1'b0, 1'b1, 16'd15500, 1'b0);
        chk_state("basic_acc", 12500, 1);
        chk("basic_ready_ramp", 32'(bus.cmd_ready), 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0);
        chk_state("basic_notick", 12500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("basic_t1", 13500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0);
        chk_state("basic_hold", 13500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("basic_t2", 14500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("basic_t3", 15500, 0);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("basic_t4", 15500, 0);

        // Clamp of an out-of-range command
        fresh_reset();
        cyc(1'b0, 1'b1, 16'd40000, 1'b0);
        chk("clamp_err", 32'(cmd_err), 1);
        chk_state("clamp_acc", 12500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b0);
        chk("clamp_err_off", 32'(cmd_err), 0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("clamp_t12", 24500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("clamp_t13", 25000, 0);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("clamp_t14", 25000, 0);

        // Retarget mid-ramp; command exactly at the limit raises no error
        fresh_reset();
        cyc(1'b0, 1'b1, 16'd25000, 1'b0);
        chk("retgt_err", 32'(cmd_err), 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("retgt_t3", 15500, 1);
        cyc(1'b0, 1'b1, 16'd14000, 1'b0);
        chk_state("retgt_acc", 15500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("retgt_t4", 14500, 1);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("retgt_t5", 14000, 0);

        // Acceptance and frame tick on the same edge
        fresh_reset();
        cyc(1'b0, 1'b1, 16'd25000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("simul_pre", 15500, 1);
        cyc(1'b0, 1'b1, 16'd10000, 1'b1);
        chk_state("simul_edge", 16500, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 16'd0, 1'b1);
            chk_state("simul_down", 32'(15500 - 1000 * i), 1);
        end
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("simul_end", 10000, 0);

        // Reset mid-ramp, then a no-op command
        cyc(1'b0, 1'b1, 16'd25000, 1'b0);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("rmid_pre", 11000, 1);
        cyc(1'b1, 1'b0, 16'd0, 1'b1);
        chk_state("rmid_rst", 12500, 0);
        chk("rmid_ready", 32'(bus.cmd_ready), 0);
        cyc(1'b0, 1'b0, 16'd0, 1'b1);
        chk_state("rmid_rel", 12500, 0);
        cyc(1'b0, 1'b1, 16'd12500, 1'b0);
        chk_state("noop_acc", 12500, 0);
        chk("noop_err", 32'(cmd_err), 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 16'd0, 1'b1);
            chk_state("noop_tick", 12500, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
